ws2812_rx: RTL and testbench

- Receive-side decoder for the WS2812 single-wire LED protocol, the counterpart of the ws2812 transmit controller.
- Samples an asynchronous WS2812 data line and measures high and low pulse widths in clock cycles.
- Decodes 0/1 bits, assembles 24-bit pixel words MSB-first, and flags frame ends on the reset (long-low) code.
- Used for chain pass-through, loopback self-test of the transmit path, and capturing external LED streams.

---
 rtl/ws2812_rx.sv | 167 ++++++++++++++++
 tb/tb_ws2812_rx.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_rx.sv
// rtl/ws2812_rx.sv - WS2812 single-wire receive decoder: pulse-width bit decode, 24-bit pixel assembly, frame-end detect.
module ws2812_rx #(
    parameter int T_GLITCH   = 10,
    parameter int T_THRESH   = 52,
    parameter int T_HIGH_MAX = 120,
    parameter int T_RST      = 5000,
    parameter int IDX_W      = 6
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             din,
    output logic [23:0]      pixel_data_out,
    output logic [IDX_W-1:0] pixel_idx_out,
    output logic             pixel_valid_out,
    output logic             frame_done_out,
    output logic [IDX_W:0]   pixel_cnt_out,
    output logic             bit_err_out
);

    localparam logic [15:0] GLITCH_C = 16'(T_GLITCH);
    localparam logic [15:0] THRESH_C = 16'(T_THRESH);
    localparam logic [15:0] HMAX_C   = 16'(T_HIGH_MAX);
    localparam logic [15:0] RST_C    = 16'(T_RST);

    typedef enum logic [1:0] {
        WAIT_RST  = 2'd0,
        IDLE      = 2'd1,
        MEAS_HIGH = 2'd2,
        MEAS_LOW  = 2'd3
    } state_t;

    state_t         state_q;
    logic [1:0]     sync_q;
    logic           line_q;
    logic           rise_q;
    logic           fall_q;
    logic [15:0]    hi_cnt_q;
    logic [15:0]    lo_cnt_q;
    logic [4:0]     bit_cnt_q;
    logic [IDX_W:0] pix_cnt_q;
    logic [23:0]    shift_q;

    logic [15:0]    hi_cnt_d;
    logic [15:0]    lo_cnt_d;
    logic [IDX_W:0] pix_cnt_d;
    logic           bit_d;
    logic [23:0]    word_d;

    // Saturating increments; the counters never wrap back into a valid range.
    assign hi_cnt_d  = (&hi_cnt_q)  ? hi_cnt_q  : hi_cnt_q + 16'd1;
    assign lo_cnt_d  = (&lo_cnt_q)  ? lo_cnt_q  : lo_cnt_q + 16'd1;
    assign pix_cnt_d = (&pix_cnt_q) ? pix_cnt_q : pix_cnt_q + 1'b1;
    assign bit_d     = (hi_cnt_q >= THRESH_C);
    assign word_d    = {shift_q[22:0], bit_d};

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q         <= WAIT_RST;
            sync_q          <= 2'b00;
            line_q          <= 1'b0;
            rise_q          <= 1'b0;
            fall_q          <= 1'b0;
            hi_cnt_q        <= 16'd0;
            lo_cnt_q        <= 16'd0;
            bit_cnt_q       <= 5'd0;
            pix_cnt_q       <= '0;
            shift_q         <= 24'd0;
            pixel_data_out  <= 24'd0;
            pixel_idx_out   <= '0;
            pixel_valid_out <= 1'b0;
            frame_done_out  <= 1'b0;
            pixel_cnt_out   <= '0;
            bit_err_out     <= 1'b0;
        end else begin
            // Two synchronizer stages, then a registered edge detect; line_q is aligned with rise_q/fall_q.
            sync_q <= {sync_q[0], din};
            line_q <= sync_q[1];
            rise_q <= sync_q[1] & ~line_q;
            fall_q <= ~sync_q[1] & line_q;

            pixel_valid_out <= 1'b0;
            frame_done_out  <= 1'b0;
            bit_err_out     <= 1'b0;

            case (state_q)
                WAIT_RST: begin
                    bit_cnt_q <= 5'd0;
                    pix_cnt_q <= '0;
                    shift_q   <= 24'd0;
                    if (line_q) begin
                        lo_cnt_q <= 16'd0;
                    end else if (lo_cnt_d >= RST_C) begin
                        lo_cnt_q <= 16'd0;
                        state_q  <= IDLE;
                    end else begin
                        lo_cnt_q <= lo_cnt_d;
                    end
                end

                IDLE: begin
                    bit_cnt_q <= 5'd0;
                    pix_cnt_q <= '0;
                    shift_q   <= 24'd0;
                    if (rise_q) begin
                        hi_cnt_q <= 16'd1;
                        state_q  <= MEAS_HIGH;
                    end
                end

                MEAS_HIGH: begin
                    // While high no falling edge can be pending, so the stuck-high check wins.
                    if (line_q) begin
                        hi_cnt_q <= hi_cnt_d;
                        if (hi_cnt_d >= HMAX_C) begin
                            bit_err_out <= 1'b1;
                            bit_cnt_q   <= 5'd0;
                            shift_q     <= 24'd0;
                            lo_cnt_q    <= 16'd0;
                            state_q     <= WAIT_RST;
                        end
                    end else if (fall_q) begin
                        if (hi_cnt_q < GLITCH_C) begin
                            bit_err_out <= 1'b1;
                            bit_cnt_q   <= 5'd0;
                            shift_q     <= 24'd0;
                            lo_cnt_q    <= 16'd0;
                            state_q     <= WAIT_RST;
                        end else begin
                            shift_q  <= word_d;
                            lo_cnt_q <= 16'd1;
                            state_q  <= MEAS_LOW;
                            if (bit_cnt_q == 5'd23) begin
                                pixel_data_out  <= word_d;
                                pixel_idx_out   <= pix_cnt_q[IDX_W-1:0];
                                pixel_valid_out <= 1'b1;
                                pix_cnt_q       <= pix_cnt_d;
                                bit_cnt_q       <= 5'd0;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 5'd1;
                            end
                        end
                    end
                end

                MEAS_LOW: begin
                    if (rise_q) begin
                        hi_cnt_q <= 16'd1;
                        state_q  <= MEAS_HIGH;
                    end else if (lo_cnt_d >= RST_C) begin
                        frame_done_out <= 1'b1;
                        pixel_cnt_out  <= pix_cnt_q;
                        bit_err_out    <= (bit_cnt_q != 5'd0);
                        bit_cnt_q      <= 5'd0;
                        shift_q        <= 24'd0;
                        lo_cnt_q       <= 16'd0;
                        state_q        <= IDLE;
                    end else begin
                        lo_cnt_q <= lo_cnt_d;
                    end
                end

                default: state_q <= WAIT_RST;
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_rx.sv
// tb/tb_ws2812_rx.sv - directed self-checking bench for ws2812_rx.
`timescale 1ns/1ps
module tb_ws2812_rx;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        din;
    logic [23:0] pixel_data_out;
    logic [5:0]  pixel_idx_out;
    logic        pixel_valid_out;
    logic        frame_done_out;
    logic [6:0]  pixel_cnt_out;
    logic        bit_err_out;

    ws2812_rx dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .din             (din),
        .pixel_data_out  (pixel_data_out),
        .pixel_idx_out   (pixel_idx_out),
        .pixel_valid_out (pixel_valid_out),
        .frame_done_out  (frame_done_out),
        .pixel_cnt_out   (pixel_cnt_out),
        .bit_err_out     (bit_err_out)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    logic [23:0] pq[$];
    logic [5:0]  iq[$];
    int          fd_n = 0;
    int          err_n = 0;
    int          co_n = 0;
    int          err_cyc = 0;
    logic [6:0]  fd_cnt = '0;

    always @(negedge clk_in) begin
        if (pixel_valid_out) begin
            pq.push_back(pixel_data_out);
            iq.push_back(pixel_idx_out);
        end
        if (frame_done_out) begin
            fd_n   = fd_n + 1;
            fd_cnt = pixel_cnt_out;
        end
        if (bit_err_out) begin
            err_n   = err_n + 1;
            err_cyc = cyc;
        end
        if (frame_done_out && bit_err_out) co_n = co_n + 1;
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        din = v;
        repeat (n) @(negedge clk_in);
    endtask

    task automatic send_bit(input logic b);
        if (b) begin
            drive(1'b1, 70);
            drive(1'b0, 55);
        end else begin
            drive(1'b1, 35);
            drive(1'b0, 90);
        end
    endtask

    task automatic send_pixel(input logic [23:0] w);
        for (int i = 23; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic send_test(input int hi);
        drive(1'b1, hi);
        drive(1'b0, 90);
        for (int i = 0; i < 23; i++) send_bit(1'b0);
    endtask

    int p0, f0, e0, c0, rc;

    initial begin
        rst_n_in = 1'b0;
        din      = 1'b0;
        repeat (3) @(negedge clk_in);
        check("rst_data", 32'(pixel_data_out), 0);
        check("rst_idx", 32'(pixel_idx_out), 0);
        check("rst_cnt", 32'(pixel_cnt_out), 0);
        check("rst_strobes", 32'({pixel_valid_out, frame_done_out, bit_err_out}), 0);
        rst_n_in = 1'b1;
        drive(1'b0, 5010);

        // Single pixel then reset code
        p0 = pq.size(); f0 = fd_n; e0 = err_n;
        send_pixel(24'hA5C30F);
        drive(1'b0, 5010);
        check("t1_npix", 32'(pq.size() - p0), 1);
        check("t1_data", 32'(pq[p0]), 'hA5C30F);
        check("t1_idx", 32'(iq[p0]), 0);
        check("t1_nframe", 32'(fd_n - f0), 1);
        check("t1_pixcnt", 32'(fd_cnt), 1);
        check("t1_noerr", 32'(err_n - e0), 0);

        // Three back-to-back pixels
        p0 = pq.size(); f0 = fd_n;
        send_pixel(24'hFF0000);
        send_pixel(24'h00FF00);
        send_pixel(24'h0000FF);
        drive(1'b0, 5010);
        check("t2_npix", 32'(pq.size() - p0), 3);
        check("t2_data0", 32'(pq[p0]), 'hFF0000);
        check("t2_data1", 32'(pq[p0+1]), 'h00FF00);
        check("t2_data2", 32'(pq[p0+2]), 'h0000FF);
        check("t2_idx0", 32'(iq[p0]), 0);
        check("t2_idx1", 32'(iq[p0+1]), 1);
        check("t2_idx2", 32'(iq[p0+2]), 2);
        check("t2_nframe", 32'(fd_n - f0), 1);
        check("t2_pixcnt", 32'(fd_cnt), 3);

        // Threshold sweep on the first bit of each pixel
        p0 = pq.size(); e0 = err_n; f0 = fd_n;
        send_test(52);
        send_test(51);
        send_test(10);
        check("t3_npix", 32'(pq.size() - p0), 3);
        check("t3_hi52", 32'(pq[p0]), 'h800000);
        check("t3_hi51", 32'(pq[p0+1]), 'h000000);
        check("t3_hi10", 32'(pq[p0+2]), 'h000000);
        check("t3_idx2", 32'(iq[p0+2]), 2);
        check("t3_noerr", 32'(err_n - e0), 0);
        send_test(9);
        check("t3_hi9_err", 32'(err_n - e0), 1);
        check("t3_hi9_nopix", 32'(pq.size() - p0), 3);
        drive(1'b0, 5010);
        check("t3_noframe", 32'(fd_n - f0), 0);

        // Stuck high mid-frame
        p0 = pq.size(); e0 = err_n; f0 = fd_n;
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        rc = cyc;
        drive(1'b1, 200);
        check("t4_err", 32'(err_n - e0), 1);
        check("t4_err_lat", 32'(err_cyc - rc), 123);
        check("t4_nopix", 32'(pq.size() - p0), 0);
        drive(1'b0, 5010);
        send_pixel(24'h3C96E1);
        drive(1'b0, 5010);
        check("t4_npix", 32'(pq.size() - p0), 1);
        check("t4_data", 32'(pq[p0]), 'h3C96E1);
        check("t4_idx", 32'(iq[p0]), 0);
        check("t4_pixcnt", 32'(fd_cnt), 1);

        // Partial pixel at frame end
        p0 = pq.size(); c0 = co_n; f0 = fd_n;
        for (int i = 0; i < 12; i++) send_bit(i[0]);
        drive(1'b0, 5010);
        check("t5_err_with_frame", 32'(co_n - c0), 1);
        check("t5_nframe", 32'(fd_n - f0), 1);
        check("t5_pixcnt", 32'(fd_cnt), 0);
        check("t5_nopix", 32'(pq.size() - p0), 0);

        // Asynchronous reset mid-pixel
        for (int i = 0; i < 10; i++) send_bit(1'b1);
        rst_n_in = 1'b0;
        #1;
        check("t6_rst_data", 32'(pixel_data_out), 0);
        check("t6_rst_idx", 32'(pixel_idx_out), 0);
        check("t6_rst_cnt", 32'(pixel_cnt_out), 0);
        check("t6_rst_strobes", 32'({pixel_valid_out, frame_done_out, bit_err_out}), 0);
        @(negedge clk_in);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        p0 = pq.size(); e0 = err_n; f0 = fd_n;
        for (int i = 0; i < 8; i++) send_bit(1'b1);
        check("t6_ignored", 32'(pq.size() - p0 + err_n - e0), 0);
        drive(1'b0, 5010);
        send_pixel(24'h5A5A5A);
        drive(1'b0, 5010);
        check("t6_npix", 32'(pq.size() - p0), 1);
        check("t6_data", 32'(pq[p0]), 'h5A5A5A);
        check("t6_idx", 32'(iq[p0]), 0);
        check("t6_nframe", 32'(fd_n - f0), 1);
        check("t6_pixcnt", 32'(fd_cnt), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
